otp_auth_ctrl: RTL and testbench



---
 rtl/otp_auth_ctrl.sv | 158 +++++++++++++++
 tb/tb_otp_auth_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/otp_auth_ctrl.sv
// ---------------------------------------------------------------------------
// otp_auth_ctrl
//   Authentication controller feeding the OTP/status display stage. It
//   captures an LFSR-generated BCD OTP on gen, collects up to four keyed
//   digits into a BCD entry, and on submit either unlocks or counts a wrong
//   attempt. The third wrong attempt locks the block for LOCK_CYCLES. A
//   captured OTP expires EXPIRE_CYCLES after capture.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   gen                pulse: capture lfsr_in as the new OTP
//   lfsr_in[15:0]      free-running BCD LFSR value
//   digit_valid        strobe qualifying digit[3:0] (0-9 accepted)
//   submit             pulse: compare the entry against the OTP
//   clear              pulse: discard the current entry
//   user_otp[15:0]     entered digits, newest digit in [3:0]
//   lfsr_otp[15:0]     captured OTP
//   unlock/lock/expire state flags, mutually exclusive
//   wrng_att[1:0]      wrong attempts in the current lock window
// ---------------------------------------------------------------------------
module otp_auth_ctrl #(
    parameter int EXPIRE_CYCLES = 1000,
    parameter int LOCK_CYCLES   = 500
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        gen,
    input  logic [15:0] lfsr_in,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        submit,
    input  logic        clear,
    output logic [15:0] user_otp,
    output logic [15:0] lfsr_otp,
    output logic        unlock,
    output logic        lock,
    output logic        expire,
    output logic [1:0]  wrng_att
);

    // One timer serves both the validity window (ENTRY) and the lockout
    // (LOCKED); the two states never overlap.
    localparam int TMAX = (EXPIRE_CYCLES > LOCK_CYCLES) ? EXPIRE_CYCLES : LOCK_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] EXP_LOAD  = TW'(EXPIRE_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

    // One-hot so the state flags come straight off flop outputs.
    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_ENTRY    = 5'b00010,
        S_UNLOCKED = 5'b00100,
        S_LOCKED   = 5'b01000,
        S_EXPIRED  = 5'b10000
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   user_q, user_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [2:0]    dcnt_q, dcnt_d;
    logic [1:0]    wrng_q, wrng_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          restart;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            user_q  <= '0;
            lfsr_q  <= '0;
            dcnt_q  <= '0;
            wrng_q  <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            user_q  <= user_d;
            lfsr_q  <= lfsr_d;
            dcnt_q  <= dcnt_d;
            wrng_q  <= wrng_d;
            tmr_q   <= tmr_d;
        end
    end

    // gen restarts from any state but LOCKED; an expiry in ENTRY beats it.
    assign restart = gen && (state_q != S_LOCKED) &&
                     !((state_q == S_ENTRY) && (tmr_q == '0));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        user_d  = user_q;
        lfsr_d  = lfsr_q;
        dcnt_d  = dcnt_q;
        wrng_d  = wrng_q;
        tmr_d   = tmr_q;
        if (restart) begin
            state_d = S_ENTRY;
            lfsr_d  = lfsr_in;
            user_d  = '0;
            dcnt_d  = '0;
            tmr_d   = EXP_LOAD;
            // A successful unlock closes the attempt window.
            if (state_q == S_UNLOCKED) wrng_d = '0;
        end else begin
            case (state_q)
                S_ENTRY: begin
                    if (tmr_q == '0) begin
                        state_d = S_EXPIRED;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                        // Compare uses pre-edge values; a coincident digit is dropped.
                        if (submit) begin
                            if ((dcnt_q == 3'd4) && (user_q == lfsr_q)) begin
                                state_d = S_UNLOCKED;
                            end else if (wrng_q == 2'd2) begin
                                state_d = S_LOCKED;
                                tmr_d   = LOCK_LOAD;
                            end else begin
                                wrng_d = wrng_q + 2'd1;
                                user_d = '0;
                                dcnt_d = '0;
                            end
                        end else if (clear) begin
                            user_d = '0;
                            dcnt_d = '0;
                        end else if (digit_valid && (digit <= 4'd9) && (dcnt_q < 3'd4)) begin
                            user_d = {user_q[11:0], digit};
                            dcnt_d = dcnt_q + 3'd1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (tmr_q == '0) begin
                        state_d = S_IDLE;
                        wrng_d  = '0;
                        user_d  = '0;
                        lfsr_d  = '0;
                        dcnt_d  = '0;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are direct register bits.
    always_comb begin
        user_otp = user_q;
        lfsr_otp = lfsr_q;
        wrng_att = wrng_q;
        unlock   = state_q[2];
        lock     = state_q[3];
        expire   = state_q[4];
    end

endmodule

// File: tb/tb_otp_auth_ctrl.sv
module tb_otp_auth_ctrl;
    localparam int EXP  = 100;
    localparam int LOCK = 50;

    logic        clk = 1'b0;
    logic        rstn;
    logic        gen, digit_valid, submit, clear;
    logic [15:0] lfsr_in;
    logic [3:0]  digit;
    logic [15:0] user_otp, lfsr_otp;
    logic        unlock, lock, expire;
    logic [1:0]  wrng_att;

    otp_auth_ctrl #(.EXPIRE_CYCLES(EXP), .LOCK_CYCLES(LOCK)) dut (
        .clk(clk), .rstn(rstn), .gen(gen), .lfsr_in(lfsr_in),
        .digit_valid(digit_valid), .digit(digit), .submit(submit), .clear(clear),
        .user_otp(user_otp), .lfsr_otp(lfsr_otp), .unlock(unlock), .lock(lock),
        .expire(expire), .wrng_att(wrng_att)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timing is kept as absolute edge deadlines; the entry as a digit list.
    localparam int M_IDLE = 0, M_ENTRY = 1, M_UNL = 2, M_LOCK = 3, M_EXP = 4;
    int          m_st;
    int          dq[$];
    logic [15:0] m_lfsr;
    int          m_w;
    int          cyc;
    int          exp_dl, lock_dl;

    function automatic logic [15:0] m_user();
        logic [15:0] v = 16'h0;
        foreach (dq[i]) v = (v << 4) | 16'(dq[i]);
        return v;
    endfunction

    task automatic m_reset();
        m_st = M_IDLE; dq.delete(); m_lfsr = 16'h0; m_w = 0; exp_dl = -1; lock_dl = -1;
    endtask

    task automatic m_edge(input logic g, input logic [15:0] l, input logic dv,
                          input logic [3:0] d, input logic s, input logic c);
        bit rs;
        rs = g && m_st != M_LOCK && !(m_st == M_ENTRY && cyc == exp_dl);
        if (rs) begin
            if (m_st == M_UNL) m_w = 0;
            m_lfsr = l; dq.delete(); exp_dl = cyc + EXP; m_st = M_ENTRY;
        end else if (m_st == M_ENTRY) begin
            if (cyc == exp_dl) m_st = M_EXP;
            else if (s) begin
                if (dq.size() == 4 && m_user() == m_lfsr) m_st = M_UNL;
                else if (m_w == 2) begin m_st = M_LOCK; lock_dl = cyc + LOCK; end
                else begin m_w++; dq.delete(); end
            end else if (c) dq.delete();
            else if (dv && d <= 9 && dq.size() < 4) dq.push_back(int'(d));
        end else if (m_st == M_LOCK && cyc == lock_dl) begin
            m_st = M_IDLE; m_w = 0; dq.delete(); m_lfsr = 16'h0;
        end
    endtask

    task automatic check_all();
        chk("user_otp", user_otp, m_user());
        chk("lfsr_otp", lfsr_otp, m_lfsr);
        chk("unlock", 16'(unlock), 16'(m_st == M_UNL));
        chk("lock", 16'(lock), 16'(m_st == M_LOCK));
        chk("expire", 16'(expire), 16'(m_st == M_EXP));
        chk("wrng_att", 16'(wrng_att), 16'(m_w));
    endtask

    // Drive one cycle of inputs, clock it, then compare 1 time unit later.
    task automatic step(input logic g, input logic [15:0] l, input logic dv,
                        input logic [3:0] d, input logic s, input logic c);
        gen = g; lfsr_in = l; digit_valid = dv; digit = d; submit = s; clear = c;
        @(posedge clk);
        m_edge(g, l, dv, d, s, c);
        cyc++;
        #1;
        check_all();
        gen = 0; digit_valid = 0; submit = 0; clear = 0;
    endtask

    task automatic idle();            step(0, 16'h0, 0, 4'h0, 0, 0); endtask
    task automatic do_gen(input logic [15:0] l); step(1, l, 0, 4'h0, 0, 0); endtask
    task automatic key(input logic [3:0] d); step(0, 16'h0, 1, d, 0, 0); endtask
    task automatic do_sub();          step(0, 16'h0, 0, 4'h0, 1, 0); endtask
    task automatic key4(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) key(v[4*i +: 4]);
    endtask

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        int n;
        logic [15:0] ltmp;
        logic [3:0]  d;
        rstn = 0; gen = 0; lfsr_in = 0; digit_valid = 0; digit = 0; submit = 0; clear = 0;
        cyc = 0;
        m_reset();
        #3;
        check_all();
        #9 rstn = 1;

        // 1: correct entry unlocks
        do_gen(16'h4721);
        key4(16'h4721);
        do_sub();
        chk("t1_unlock", 16'(unlock), 16'h1);
        chk("t1_user", user_otp, 16'h4721);

        // 2: three wrong attempts lock; gen in lock ignored; lock lasts LOCK cycles
        do_gen(16'h1234);
        key4(16'h1235); do_sub();
        chk("t2_w1", 16'(wrng_att), 16'h1);
        key4(16'h1235); do_sub();
        key4(16'h1235); do_sub();
        chk("t2_lock", 16'(lock), 16'h1);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step(i == 1, 16'h9999, 0, 4'h0, 0, 0);
            if (!lock) begin n = i; break; end
        end
        chk("t2_lock_len", 16'(n), 16'(LOCK));
        chk("t2_lfsr_clr", lfsr_otp, 16'h0);

        // 3: expiry latency, with one wrong attempt inside the window
        do_gen(16'h5555);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            step(0, 16'h0, 0, 4'h0, i == 1, 0);
            if (expire) begin n = i; break; end
        end
        chk("t3_exp_lat", 16'(n), 16'(EXP));
        key4(16'h5555); do_sub();
        chk("t3_no_unlock", 16'(unlock), 16'h0);
        do_gen(16'h2468);
        chk("t3_w_kept", 16'(wrng_att), 16'h1);

        // 4: entry edge cases
        key(4'hA);
        key4(16'h9876); key(4'h5);
        chk("t4_five", user_otp, 16'h9876);
        step(0, 16'h0, 0, 4'h0, 0, 1);
        key(4'h1); key(4'h2);
        chk("t4_two", user_otp, 16'h0012);
        do_sub();
        chk("t4_short", 16'(wrng_att), 16'h2);

        // 5: submit at expiry; submit with coincident digit
        do_gen(16'h1357);
        for (int i = 1; i < EXP; i++) idle();
        do_sub();
        chk("t5_exp", 16'(expire), 16'h1);
        chk("t5_w", 16'(wrng_att), 16'h2);
        do_gen(16'h1357);
        key4(16'h1357);
        step(0, 16'h0, 1, 4'h3, 1, 0);
        chk("t5_unl", 16'(unlock), 16'h1);
        chk("t5_nodig", user_otp, 16'h1357);

        // 6: async reset mid-entry
        do_gen(16'h1111);
        do_sub();
        key(4'h4); key(4'h5);
        chk("t6_pre", user_otp, 16'h0045);
        rstn = 0;
        #1;
        m_reset();
        check_all();
        #2 rstn = 1;
        key(4'h7);
        chk("t6_idle", user_otp, 16'h0);

        // random phase
        for (int k = 0; k < 4000; k++) begin
            ltmp = ($urandom_range(0, 99) < 3) ? rnd_bcd() : 16'h0;
            if (m_st == M_ENTRY && dq.size() < 4 && $urandom_range(0, 9) < 7)
                d = m_lfsr[4*(3 - dq.size()) +: 4];
            else
                d = 4'($urandom_range(0, 15));
            step(ltmp != 16'h0 || $urandom_range(0, 199) == 0, ltmp,
                 1'($urandom_range(0, 1)), d,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 59) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
